// File: rtl/rgb_led_pkg.sv
// Shared types and colour map for the RGB LED scheduler.
package rgb_led_pkg;

    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [2:0] colour_of(input logic [1:0] idx);
        logic [2:0] col;
        case (idx)
            2'd0:    col = COL_RED;
            2'd1:    col = COL_GREEN;
            2'd2:    col = COL_BLUE;
            default: col = COL_WHITE;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/rgb_rr_arbiter.sv
// 4-way combinational arbiter: fixed priority (mode=0) or rotating from ptr (mode=1).
module rgb_rr_arbiter (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       mode,
    output logic       win_valid,
    output logic [1:0] win_idx,
    output logic [3:0] win_onehot
);

    logic [1:0] start;
    logic [1:0] cand;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        start     = mode ? ptr : 2'd0;
        // First set bit found while scanning upward (mod 4) from start wins.
        for (int i = 0; i < 4; i++) begin
            cand = start + 2'(i);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot = win_valid ? (4'b0001 << win_idx) : 4'b0000;
    end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Time-shares one RGB LED between four button requesters with a fixed hold
// window per owner and a single dark cycle between owners.
//   state | meaning
//   IDLE  | no owner, arbitrate every cycle
//   GRANT | owner drives LED, timer counts down to 0
//   GAP   | one dark cycle, then arbitrate again
module rgb_led_scheduler
    import rgb_led_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch0,
    input  logic       switch1,
    input  logic [3:0] button,
    output logic [2:0] RGB_LED,
    output logic [3:0] grant,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         pending_q, pending_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         grant_q, grant_d;
    logic [2:0]         rgb_q, rgb_d;

    logic [3:0] req;
    logic       win_valid;
    logic [1:0] win_idx;
    logic [3:0] win_onehot;

    assign req = pending_q | button;

    rgb_rr_arbiter u_arb (
        .req        (req),
        .ptr        (rr_ptr_q),
        .mode       (switch1),
        .win_valid  (win_valid),
        .win_idx    (win_idx),
        .win_onehot (win_onehot)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        grant_d   = grant_q;
        rgb_d     = rgb_q;

        if (!switch0) begin
            // rr_ptr is deliberately kept so fairness survives a disable.
            state_d   = IDLE;
            pending_d = 4'b0000;
            timer_d   = '0;
            grant_d   = 4'b0000;
            rgb_d     = 3'b000;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    state_d   = IDLE;
                    pending_d = req;
                    grant_d   = 4'b0000;
                    rgb_d     = 3'b000;
                    if (win_valid) begin
                        state_d   = GRANT;
                        pending_d = req & ~win_onehot;
                        rr_ptr_d  = win_idx + 2'd1;
                        timer_d   = HOLD_LOAD;
                        grant_d   = win_onehot;
                        rgb_d     = colour_of(win_idx);
                    end
                end
                GRANT: begin
                    pending_d = req;
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIMER_W'(1);
                    end else begin
                        state_d = GAP;
                        grant_d = 4'b0000;
                        rgb_d   = 3'b000;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = 4'b0000;
                    timer_d   = '0;
                    grant_d   = 4'b0000;
                    rgb_d     = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            rr_ptr_q  <= 2'd0;
            timer_q   <= '0;
            grant_q   <= 4'b0000;
            rgb_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            grant_q   <= grant_d;
            rgb_q     <= rgb_d;
        end
    end

    assign RGB_LED = rgb_q;
    assign grant   = grant_q;
    assign busy    = (state_q == GRANT) || (state_q == GAP);

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Directed bench for rgb_led_scheduler with HOLD_CYCLES=8.
module tb_rgb_led_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       switch0;
    logic       switch1;
    logic [3:0] button;
    logic [2:0] RGB_LED;
    logic [3:0] grant;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    rgb_led_scheduler #(.HOLD_CYCLES(8), .TIMER_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .switch0 (switch0),
        .switch1 (switch1),
        .button  (button),
        .RGB_LED (RGB_LED),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic [2:0] c, input logic b);
        n_assert++;
        assert ({grant, RGB_LED, busy} === {g, c, b})
        else begin
            n_fail++;
            $error("FAIL %s: observed grant=%b rgb=%b busy=%b, expected grant=%b rgb=%b busy=%b",
                   tag, grant, RGB_LED, busy, g, c, b);
        end
    endtask

    // Eight owner cycles, the first being the grant edge.
    task automatic owner(input string tag, input logic [3:0] g, input logic [2:0] c);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk(tag, g, c, 1'b1);
        end
    endtask

    task automatic gap(input string tag);
        tick();
        chk(tag, 4'b0000, 3'b000, 1'b1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        button = 4'b0000;
        tick();
        chk("reset_clear", 4'b0000, 3'b000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset dominates held buttons, first edge after release grants req0
        reset   = 1'b1;
        switch0 = 1'b1;
        switch1 = 1'b0;
        button  = 4'b1111;
        tick();
        chk("reset_c1", 4'b0000, 3'b000, 1'b0);
        tick();
        chk("reset_c2", 4'b0000, 3'b000, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_reset_grant", 4'b0001, 3'b100, 1'b1);

        // reset mid-GRANT clears everything, then idle with no requests
        do_reset();
        tick();
        chk("idle_no_req", 4'b0000, 3'b000, 1'b0);

        // 2: held req0 repeats with period 9
        button = 4'b0001;
        owner("t2_own_a", 4'b0001, 3'b100);
        gap("t2_gap_a");
        owner("t2_own_b", 4'b0001, 3'b100);
        gap("t2_gap_b");
        tick();
        chk("t2_own_c_first", 4'b0001, 3'b100, 1'b1);
        button = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t2_own_c_rest", 4'b0001, 3'b100, 1'b1);
        end
        gap("t2_gap_c");
        tick();
        chk("t2_back_idle", 4'b0000, 3'b000, 1'b0);

        // 3: fixed priority starves req2
        switch1 = 1'b0;
        button  = 4'b0110;
        owner("t3_own_a", 4'b0010, 3'b010);
        gap("t3_gap_a");
        owner("t3_own_b", 4'b0010, 3'b010);
        gap("t3_gap_b");
        owner("t3_own_c", 4'b0010, 3'b010);

        // 4: round-robin over all four requesters
        switch1 = 1'b1;
        do_reset();
        button = 4'b1111;
        owner("t4_req0", 4'b0001, 3'b100);
        gap("t4_gap0");
        owner("t4_req1", 4'b0010, 3'b010);
        gap("t4_gap1");
        owner("t4_req2", 4'b0100, 3'b001);
        gap("t4_gap2");
        owner("t4_req3", 4'b1000, 3'b111);
        gap("t4_gap3");
        owner("t4_req0_again", 4'b0001, 3'b100);

        // 5: one-cycle pulse on req3 during req0's window is remembered
        switch1 = 1'b0;
        do_reset();
        tick();
        chk("t5_idle", 4'b0000, 3'b000, 1'b0);
        button = 4'b0001;
        tick();
        chk("t5_own0_1", 4'b0001, 3'b100, 1'b1);
        button = 4'b0000;
        tick();
        chk("t5_own0_2", 4'b0001, 3'b100, 1'b1);
        button = 4'b1000;
        tick();
        chk("t5_own0_3", 4'b0001, 3'b100, 1'b1);
        button = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_own0_rest", 4'b0001, 3'b100, 1'b1);
        end
        gap("t5_gap0");
        owner("t5_own3", 4'b1000, 3'b111);
        gap("t5_gap3");
        tick();
        chk("t5_idle_after", 4'b0000, 3'b000, 1'b0);

        // 6: disable mid-GRANT drops outputs and pending requests
        button = 4'b0100;
        tick();
        chk("t6_own2_1", 4'b0100, 3'b001, 1'b1);
        button = 4'b0001;
        tick();
        chk("t6_own2_2", 4'b0100, 3'b001, 1'b1);
        button = 4'b0000;
        tick();
        chk("t6_own2_3", 4'b0100, 3'b001, 1'b1);
        switch0 = 1'b0;
        tick();
        chk("t6_disabled", 4'b0000, 3'b000, 1'b0);
        button = 4'b1111;
        tick();
        chk("t6_disabled_ignores_btn", 4'b0000, 3'b000, 1'b0);
        button  = 4'b0000;
        switch0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_reenabled_idle", 4'b0000, 3'b000, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
